// File: rtl/cache_arb_pkg.sv
// Shared types for the icache/dcache to memory arbiter.
// Holds the FSM encoding, source IDs and the held request control bundle.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_ICACHE_REQ = 2'd1,
        ARB_DCACHE_REQ = 2'd2
    } arb_state_e;

    localparam logic SRC_ICACHE = 1'b0;
    localparam logic SRC_DCACHE = 1'b1;

    // Width-independent part of a held memory request.
    typedef struct packed {
        logic src;
        logic we;
    } mem_req_t;

endpackage

// File: rtl/cache_arb_rr2.sv
// Two-way round-robin grant; bit 0 is icache, bit 1 is dcache.
// The pointer moves to the source that was not granted.
module cache_arb_rr2
    import cache_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b11:   gnt = (ptr_q == SRC_DCACHE) ? 2'b10 : 2'b01;
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= SRC_ICACHE;
        end else if (|gnt) begin
            ptr_q <= gnt[0] ? SRC_DCACHE : SRC_ICACHE;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache refills and dcache reads/writes onto one memory port.
// Tracks outstanding stores and the single icache refill; routes returns.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int MemTidWidth          = 2,
    parameter int MaxOutstandingStores = 7,
    parameter int AddrWidth            = 64,
    parameter int DataWidth            = 64,
    parameter int LineWidth            = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   icache_req_valid_i,
    output logic                   icache_req_ready_o,
    input  logic [AddrWidth-1:0]   icache_req_addr_i,
    output logic                   icache_rtrn_valid_o,
    output logic [LineWidth-1:0]   icache_rtrn_data_o,
    input  logic                   dcache_req_valid_i,
    output logic                   dcache_req_ready_o,
    input  logic                   dcache_req_we_i,
    input  logic [AddrWidth-1:0]   dcache_req_addr_i,
    input  logic [DataWidth-1:0]   dcache_req_wdata_i,
    input  logic [MemTidWidth-1:0] dcache_req_tid_i,
    output logic                   dcache_rtrn_valid_o,
    output logic                   dcache_rtrn_we_o,
    output logic [MemTidWidth-1:0] dcache_rtrn_tid_o,
    output logic [LineWidth-1:0]   dcache_rtrn_data_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic                   mem_req_src_o,
    output logic                   mem_req_we_o,
    output logic [AddrWidth-1:0]   mem_req_addr_o,
    output logic [DataWidth-1:0]   mem_req_wdata_o,
    output logic [MemTidWidth-1:0] mem_req_tid_o,
    input  logic                   mem_rtrn_valid_i,
    input  logic                   mem_rtrn_src_i,
    input  logic                   mem_rtrn_we_i,
    input  logic [MemTidWidth-1:0] mem_rtrn_tid_i,
    input  logic [LineWidth-1:0]   mem_rtrn_data_i,
    output logic [$clog2(MaxOutstandingStores+1)-1:0] stores_pending_o,
    output logic                   idle_o
);

    localparam int CntW = $clog2(MaxOutstandingStores + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstandingStores);

    arb_state_e state_q, state_d;
    mem_req_t   ctrl_q;

    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [MemTidWidth-1:0] tid_q;
    logic [CntW-1:0]        cnt_q;
    logic                   ic_pend_q;

    logic       in_idle;
    logic       ic_elig;
    logic       dc_elig;
    logic [1:0] gnt;
    logic       wr_hs;
    logic       wr_ack;
    logic       ic_rtrn;

    assign in_idle = (state_q == ARB_IDLE);
    assign ic_elig = icache_req_valid_i & ~ic_pend_q;
    assign dc_elig = dcache_req_valid_i
                   & (~dcache_req_we_i | (cnt_q < MaxCnt));

    cache_arb_rr2 u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({dc_elig, ic_elig}),
        .en     (in_idle),
        .gnt    (gnt)
    );

    assign icache_req_ready_o = gnt[0];
    assign dcache_req_ready_o = gnt[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (1'b1)
                    gnt[0]:  state_d = ARB_ICACHE_REQ;
                    gnt[1]:  state_d = ARB_DCACHE_REQ;
                    default: state_d = ARB_IDLE;
                endcase
            end
            ARB_ICACHE_REQ, ARB_DCACHE_REQ: begin
                if (mem_req_ready_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ARB_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tid_q   <= '0;
        end else if (gnt[0]) begin
            ctrl_q  <= '{src: SRC_ICACHE, we: 1'b0};
            addr_q  <= icache_req_addr_i;
            wdata_q <= '0;
            tid_q   <= '0;
        end else if (gnt[1]) begin
            ctrl_q  <= '{src: SRC_DCACHE, we: dcache_req_we_i};
            addr_q  <= dcache_req_addr_i;
            wdata_q <= dcache_req_wdata_i;
            tid_q   <= dcache_req_tid_i;
        end
    end

    assign mem_req_valid_o = ~in_idle;
    assign mem_req_src_o   = ctrl_q.src;
    assign mem_req_we_o    = ctrl_q.we;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_tid_o   = tid_q;

    // Saturating guards keep a stray ack or overflow from wrapping the count.
    assign wr_hs  = mem_req_valid_o & mem_req_ready_i & ctrl_q.we
                  & (cnt_q != MaxCnt);
    assign wr_ack = mem_rtrn_valid_i & (mem_rtrn_src_i == SRC_DCACHE)
                  & mem_rtrn_we_i & (cnt_q != '0);
    assign ic_rtrn = mem_rtrn_valid_i & (mem_rtrn_src_i == SRC_ICACHE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            unique case ({wr_hs, wr_ack})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ic_pend_q <= 1'b0;
        else if (gnt[0])  ic_pend_q <= 1'b1;
        else if (ic_rtrn) ic_pend_q <= 1'b0;
    end

    assign icache_rtrn_valid_o = ic_rtrn;
    assign icache_rtrn_data_o  = mem_rtrn_data_i;
    assign dcache_rtrn_valid_o = mem_rtrn_valid_i
                               & (mem_rtrn_src_i == SRC_DCACHE);
    assign dcache_rtrn_we_o    = mem_rtrn_we_i;
    assign dcache_rtrn_tid_o   = mem_rtrn_tid_i;
    assign dcache_rtrn_data_o  = mem_rtrn_data_i;

    assign stores_pending_o = cnt_q;
    assign idle_o = in_idle & (cnt_q == '0) & ~ic_pend_q;

    ack_without_store: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(mem_rtrn_valid_i && mem_rtrn_src_i && mem_rtrn_we_i
          && cnt_q == '0))
        else $error("write ack with no store outstanding");

    refill_without_req: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(ic_rtrn && !ic_pend_q))
        else $error("icache return with no refill outstanding");

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ic_valid, ic_ready;
    logic [63:0]  ic_addr;
    logic         ic_rvalid;
    logic [127:0] ic_rdata;
    logic         dc_valid, dc_ready, dc_we;
    logic [63:0]  dc_addr, dc_wdata;
    logic [1:0]   dc_tid;
    logic         dc_rvalid, dc_rwe;
    logic [1:0]   dc_rtid;
    logic [127:0] dc_rdata;
    logic         m_valid, m_ready, m_src, m_we;
    logic [63:0]  m_addr, m_wdata;
    logic [1:0]   m_tid;
    logic         r_valid, r_src, r_we;
    logic [1:0]   r_tid;
    logic [127:0] r_data;
    logic [2:0]   stores;
    logic         idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .icache_req_valid_i  (ic_valid),
        .icache_req_ready_o  (ic_ready),
        .icache_req_addr_i   (ic_addr),
        .icache_rtrn_valid_o (ic_rvalid),
        .icache_rtrn_data_o  (ic_rdata),
        .dcache_req_valid_i  (dc_valid),
        .dcache_req_ready_o  (dc_ready),
        .dcache_req_we_i     (dc_we),
        .dcache_req_addr_i   (dc_addr),
        .dcache_req_wdata_i  (dc_wdata),
        .dcache_req_tid_i    (dc_tid),
        .dcache_rtrn_valid_o (dc_rvalid),
        .dcache_rtrn_we_o    (dc_rwe),
        .dcache_rtrn_tid_o   (dc_rtid),
        .dcache_rtrn_data_o  (dc_rdata),
        .mem_req_valid_o     (m_valid),
        .mem_req_ready_i     (m_ready),
        .mem_req_src_o       (m_src),
        .mem_req_we_o        (m_we),
        .mem_req_addr_o      (m_addr),
        .mem_req_wdata_o     (m_wdata),
        .mem_req_tid_o       (m_tid),
        .mem_rtrn_valid_i    (r_valid),
        .mem_rtrn_src_i      (r_src),
        .mem_rtrn_we_i       (r_we),
        .mem_rtrn_tid_i      (r_tid),
        .mem_rtrn_data_i     (r_data),
        .stores_pending_o    (stores),
        .idle_o              (idle)
    );

    task automatic clear_in();
        ic_valid = 0; ic_addr = '0;
        dc_valid = 0; dc_we = 0; dc_addr = '0;
        dc_wdata = '0; dc_tid = '0;
        m_ready = 0;
        r_valid = 0; r_src = 0; r_we = 0;
        r_tid = '0; r_data = '0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_in();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Starts and ends at a negedge with the arbiter idle.
    task automatic issue_write(input logic [63:0] a);
        dc_valid = 1; dc_we = 1; dc_addr = a;
        dc_wdata = ~a; dc_tid = a[1:0];
        @(negedge clk);
        dc_valid = 0; m_ready = 1;
        @(negedge clk);
        m_ready = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        #2;
        checks++;
        if ({m_valid, stores, idle, ic_ready, dc_ready} !== 7'b0_000_1_00) begin
            errors++;
            $display("FAIL reset_state got v=%b cnt=%0d idle=%b rdy=%b%b want v=0 cnt=0 idle=1 rdy=00",
                     m_valid, stores, idle, ic_ready, dc_ready);
        end
        checks++;
        if ({m_addr, m_wdata, m_tid, m_src, m_we} !== '0) begin
            errors++;
            $display("FAIL reset_fields got addr=%h wdata=%h tid=%0d want all 0",
                     m_addr, m_wdata, m_tid);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_round_robin();
        logic [63:0] a1, a2;
        logic [127:0] d;
        a1 = 64'h1000_0040; a2 = 64'h2000_0080;
        d = {4{32'hC0DE_0001}};
        apply_reset();
        ic_valid = 1; ic_addr = a1;
        dc_valid = 1; dc_we = 0; dc_addr = a2;
        #1;
        checks++;
        if ({ic_ready, dc_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rr_first_grant got %b%b want 10", ic_ready, dc_ready);
        end
        @(negedge clk);
        ic_valid = 0;
        #1;
        checks++;
        if ({m_valid, m_src, m_addr, dc_ready} !== {2'b10, a1, 1'b0}) begin
            errors++;
            $display("FAIL rr_icache_issue got v=%b src=%b addr=%h drdy=%b want v=1 src=0 addr=%h drdy=0",
                     m_valid, m_src, m_addr, dc_ready, a1);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0; ic_valid = 1;
        #1;
        checks++;
        if ({ic_ready, dc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rr_second_grant got %b%b want 01", ic_ready, dc_ready);
        end
        @(negedge clk);
        r_valid = 1; r_src = 0; r_data = d;
        #1;
        checks++;
        if ({m_valid, m_src, m_addr} !== {2'b11, a2}) begin
            errors++;
            $display("FAIL rr_dcache_issue got v=%b src=%b addr=%h want v=1 src=1 addr=%h",
                     m_valid, m_src, m_addr, a2);
        end
        checks++;
        if ({ic_rvalid, dc_rvalid, ic_rdata} !== {2'b10, d}) begin
            errors++;
            $display("FAIL ic_return_route got iv=%b dv=%b data=%h want iv=1 dv=0 data=%h",
                     ic_rvalid, dc_rvalid, ic_rdata, d);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0; r_valid = 0;
        #1;
        checks++;
        if ({ic_ready, dc_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rr_rotate_back got %b%b want 10", ic_ready, dc_ready);
        end
    endtask

    task automatic test_store_limit();
        apply_reset();
        for (int i = 0; i < 7; i++) issue_write(64'h100 + 64'(i));
        dc_valid = 1; dc_we = 1; dc_addr = 64'h900;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({stores, dc_ready, idle} !== {3'd7, 2'b00}) begin
                errors++;
                $display("FAIL store_limit cyc%0d got cnt=%0d rdy=%b idle=%b want cnt=7 rdy=0 idle=0",
                         k, stores, dc_ready, idle);
            end
            @(negedge clk);
        end
        r_valid = 1; r_src = 1; r_we = 1; r_tid = 2'd1;
        @(negedge clk);
        r_valid = 0;
        #1;
        checks++;
        if ({stores, dc_ready} !== {3'd6, 1'b1}) begin
            errors++;
            $display("FAIL store_after_ack got cnt=%0d rdy=%b want cnt=6 rdy=1",
                     stores, dc_ready);
        end
        @(negedge clk);
        dc_valid = 0;
        #1;
        checks++;
        if ({m_valid, m_we, m_addr} !== {2'b11, 64'h900}) begin
            errors++;
            $display("FAIL store_reissue got v=%b we=%b addr=%h want v=1 we=1 addr=900",
                     m_valid, m_we, m_addr);
        end
    endtask

    task automatic test_simul_ack();
        apply_reset();
        for (int i = 0; i < 3; i++) issue_write(64'h40 * 64'(i));
        dc_valid = 1; dc_we = 1; dc_addr = 64'hABC0;
        @(negedge clk);
        dc_valid = 0; m_ready = 1;
        r_valid = 1; r_src = 1; r_we = 1;
        @(negedge clk);
        m_ready = 0; r_valid = 0;
        #1;
        checks++;
        if ({stores, m_valid} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL simul_ack got cnt=%0d v=%b want cnt=3 v=0", stores, m_valid);
        end
        r_valid = 1;
        @(negedge clk);
        r_valid = 0;
        #1;
        checks++;
        if (stores !== 3'd2) begin
            errors++;
            $display("FAIL lone_ack got cnt=%0d want 2", stores);
        end
    endtask

    task automatic test_stall();
        logic [63:0] a, w;
        logic [1:0] t;
        a = {$urandom, $urandom}; w = {$urandom, $urandom}; t = 2'd3;
        apply_reset();
        dc_valid = 1; dc_we = 1; dc_addr = a; dc_wdata = w; dc_tid = t;
        @(negedge clk);
        dc_addr = ~a; dc_wdata = ~w; dc_tid = 2'd0; dc_we = 0;
        ic_valid = 1; ic_addr = 64'h77;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({m_valid, m_addr, m_wdata, m_tid, ic_ready, dc_ready}
                !== {1'b1, a, w, t, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold cyc%0d got v=%b addr=%h wd=%h tid=%0d rdy=%b%b want v=1 addr=%h wd=%h tid=%0d rdy=00",
                         k, m_valid, m_addr, m_wdata, m_tid, ic_ready, dc_ready, a, w, t);
            end
            @(negedge clk);
        end
        ic_valid = 0; dc_valid = 0; m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        #1;
        checks++;
        if ({m_valid, stores} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL stall_release got v=%b cnt=%0d want v=0 cnt=1", m_valid, stores);
        end
    endtask

    task automatic test_return_route();
        logic [127:0] d;
        d = {16{8'hA5}};
        apply_reset();
        r_valid = 1; r_src = 1; r_we = 0; r_tid = 2'd2; r_data = d;
        #1;
        checks++;
        if ({dc_rvalid, dc_rtid, dc_rwe, ic_rvalid, dc_rdata}
            !== {1'b1, 2'd2, 2'b00, d}) begin
            errors++;
            $display("FAIL dc_return_route got dv=%b tid=%0d we=%b iv=%b data=%h want dv=1 tid=2 we=0 iv=0 data=%h",
                     dc_rvalid, dc_rtid, dc_rwe, ic_rvalid, dc_rdata, d);
        end
        r_valid = 0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) issue_write(64'h800 + 64'(i));
        dc_valid = 1; dc_we = 1; dc_addr = 64'h880;
        @(negedge clk);
        dc_valid = 0;
        #1;
        checks++;
        if ({m_valid, stores} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL pre_reset got v=%b cnt=%0d want v=1 cnt=4", m_valid, stores);
        end
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({m_valid, stores, idle} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got v=%b cnt=%0d idle=%b want v=0 cnt=0 idle=1",
                     m_valid, stores, idle);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        bit          busy, ic_pend, dc_turn;
        bit          h_src, h_we;
        logic [63:0] h_addr, h_wdata;
        logic [1:0]  h_tid;
        int          cnt;
        bit          ic_el, dc_el, g_ic, g_dc;
        int          r;
        apply_reset();
        busy = 0; ic_pend = 0; dc_turn = 0; cnt = 0;
        h_src = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_tid = '0;
        for (int c = 0; c < 400; c++) begin
            ic_valid = 1'($urandom);
            ic_addr  = {$urandom, $urandom};
            dc_valid = 1'($urandom);
            dc_we    = ($urandom_range(0, 3) != 0);
            dc_addr  = {$urandom, $urandom};
            dc_wdata = {$urandom, $urandom};
            dc_tid   = 2'($urandom);
            m_ready  = ($urandom_range(0, 2) != 0);
            r_valid = 0; r_src = 0; r_we = 0;
            r_tid = 2'($urandom);
            r_data = {$urandom, $urandom, $urandom, $urandom};
            r = $urandom_range(0, 5);
            if (r == 0 && ic_pend) begin
                r_valid = 1; r_src = 0; r_we = 0;
            end else if (r == 1 && cnt > 0) begin
                r_valid = 1; r_src = 1; r_we = 1;
            end else if (r == 2) begin
                r_valid = 1; r_src = 1; r_we = 0;
            end
            ic_el = ic_valid && !ic_pend;
            dc_el = dc_valid && (!dc_we || cnt < 7);
            g_ic = !busy && ic_el && (!dc_el || !dc_turn);
            g_dc = !busy && dc_el && (!ic_el || dc_turn);
            #1;
            checks++;
            if ({ic_ready, dc_ready} !== {g_ic, g_dc}) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got %b%b want %b%b",
                         c, ic_ready, dc_ready, g_ic, g_dc);
            end
            checks++;
            if ({m_valid, stores, idle}
                !== {busy, 3'(cnt), !busy && cnt == 0 && !ic_pend}) begin
                errors++;
                $display("FAIL rnd_status c=%0d got v=%b cnt=%0d idle=%b want v=%b cnt=%0d",
                         c, m_valid, stores, idle, busy, cnt);
            end
            if (busy) begin
                checks++;
                if ({m_src, m_we, m_addr, m_wdata, m_tid}
                    !== {h_src, h_we, h_addr, h_wdata, h_tid}) begin
                    errors++;
                    $display("FAIL rnd_req c=%0d got src=%b we=%b addr=%h wd=%h tid=%0d want src=%b we=%b addr=%h wd=%h tid=%0d",
                             c, m_src, m_we, m_addr, m_wdata, m_tid,
                             h_src, h_we, h_addr, h_wdata, h_tid);
                end
            end
            checks++;
            if ({ic_rvalid, dc_rvalid, dc_rtid, dc_rwe, dc_rdata, ic_rdata}
                !== {r_valid && !r_src, r_valid && r_src, r_tid, r_we, r_data, r_data}) begin
                errors++;
                $display("FAIL rnd_return c=%0d got iv=%b dv=%b tid=%0d we=%b",
                         c, ic_rvalid, dc_rvalid, dc_rtid, dc_rwe);
            end
            if (busy && m_ready) begin
                if (h_we) cnt++;
                busy = 0;
            end
            if (r_valid && r_src && r_we) cnt--;
            if (r_valid && !r_src) ic_pend = 0;
            if (g_ic) begin
                busy = 1; ic_pend = 1; dc_turn = 1;
                h_src = 0; h_we = 0; h_addr = ic_addr;
                h_wdata = '0; h_tid = '0;
            end else if (g_dc) begin
                busy = 1; dc_turn = 0;
                h_src = 1; h_we = dc_we; h_addr = dc_addr;
                h_wdata = dc_wdata; h_tid = dc_tid;
            end
            @(negedge clk);
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_round_robin();
        test_store_limit();
        test_simul_ack();
        test_stall();
        test_return_route();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
